// File: rtl/wbuart_pkg.sv
// Shared constants and types for the Wishbone UART buffer: register map,
// STATUS/IRQ bit positions and the transmit drain state encoding.
package wbuart_pkg;

   // Register addresses, decoded from i_wb_addr[1:0]
   localparam logic [1:0] ADDR_STATUS = 2'd0;
   localparam logic [1:0] ADDR_DATA   = 2'd1;
   localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   // STATUS write-side control bits
   localparam int ST_RX_OVERRUN  = 31;
   localparam int ST_TX_OVERFLOW = 30;
   localparam int ST_RX_FLUSH    = 0;
   localparam int ST_TX_FLUSH    = 1;

   // Interrupt source bit positions
   localparam int IRQ_RX_AVAIL   = 0;
   localparam int IRQ_TX_EMPTY   = 1;
   localparam int IRQ_RX_OVERRUN = 2;
   localparam int IRQ_W          = 3;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_HOLD = 2'd2
   } tx_state_t;

   // Assemble the STATUS read word from flags and 12-bit zero-extended counts
   function automatic logic [31:0] pack_status(input logic       rx_overrun,
                                               input logic       tx_overflow,
                                               input logic       tx_full,
                                               input logic [11:0] tx_count,
                                               input logic [11:0] rx_count);
      return {rx_overrun, tx_overflow, tx_full, 1'b0, tx_count, 4'h0, rx_count};
   endfunction

endpackage

// File: rtl/wbuart_fifo_sync_fifo.sv
// Byte FIFO with AW+1 bit pointers (full depth usable), flush, registered
// read port and an optional drop-oldest policy on push-while-full.
module sync_fifo #(
   parameter int AW          = 4,
   parameter bit DROP_OLDEST = 1'b0
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_flush,
   input  logic          i_push,
   input  logic [7:0]    i_push_data,
   input  logic          i_pop,
   output logic [7:0]    o_rd_data,
   output logic [AW:0]   o_count,
   output logic          o_full,
   output logic          o_empty,
   output logic          o_overflow
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   logic [7:0]  mem_q [0:(1 << AW) - 1];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]  rd_data_q;
   logic        do_push;
   logic        do_pop;

   // Occupancy, push/pop qualification and next pointer values
   always_comb begin
      o_count    = wr_ptr_q - rd_ptr_q;
      o_full     = (o_count == DEPTH);
      o_empty    = (wr_ptr_q == rd_ptr_q);
      do_pop     = i_pop & ~o_empty;
      // A full FIFO only takes a byte if a slot frees up this cycle, or if
      // it is allowed to sacrifice its oldest entry.
      do_push    = i_push & ~i_flush & (~o_full | do_pop | DROP_OLDEST);
      o_overflow = i_push & ~i_flush & o_full & ~do_pop;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         // Either a real pop or a drop-oldest overwrite advances the read
         // side; with push+pop while full both coincide into one step.
         if (do_pop || (do_push && o_full)) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   // Pointer state and registered read of the head entry on pop
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         rd_data_q <= 8'h00;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_pop) begin
            rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
         end
      end
   end

   // Storage array write port (no reset so it maps onto block RAM)
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= i_push_data;
      end
   end

   assign o_rd_data = rd_data_q;

endmodule

// File: rtl/wbuart_fifo.sv
// Wishbone-attached UART buffer: RX FIFO (drop-oldest on overrun), TX FIFO
// drained by a three-state FSM, sticky error flags, flush and masked IRQ.
module wbuart_fifo
   import wbuart_pkg::*;
#(
   parameter int RX_AW = 9,
   parameter int TX_AW = 4
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_rx_data,
   input  logic        i_rx_stb,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_stb,
   input  logic        i_tx_busy,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_we,
   input  logic [3:0]  i_wb_sel,
   input  logic [29:0] i_wb_addr,
   input  logic [31:0] i_wb_data,
   output logic        o_wb_stall,
   output logic        o_wb_ack,
   output logic        o_wb_err,
   output logic [31:0] o_wb_data,
   output logic        o_irq
);

   // Bus request decode
   logic       accept, wb_wr, wb_rd;
   logic [1:0] addr;
   logic       status_wr, irq_en_wr;

   // FIFO interfaces
   logic              rx_pop, rx_flush, rx_full, rx_empty, rx_ovf;
   logic [7:0]        rx_rd_data;
   logic [RX_AW:0]    rx_count;
   logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_ovf;
   logic [TX_AW:0]    tx_count;

   // Register state
   logic              rx_overrun_q, rx_overrun_d;
   logic              tx_overflow_q, tx_overflow_d;
   logic [IRQ_W-1:0]  irq_en_q;
   logic [IRQ_W-1:0]  pending;
   logic              irq_q;
   logic              ack_q;
   logic              data_sel_q;
   logic              rd_valid_q;
   logic [31:0]       wb_data_q, wb_data_d;
   tx_state_t         tx_state_q, tx_state_d;

   logic              unused_bits;

   assign unused_bits = ^{i_wb_sel, i_wb_addr[29:2]};

   assign accept    = i_wb_cyc & i_wb_stb;
   assign wb_wr     = accept & i_wb_we;
   assign wb_rd     = accept & ~i_wb_we;
   assign addr      = i_wb_addr[1:0];
   assign status_wr = wb_wr & (addr == ADDR_STATUS);
   assign irq_en_wr = wb_wr & (addr == ADDR_IRQ_EN);
   assign rx_pop    = wb_rd & (addr == ADDR_DATA);
   assign tx_push   = wb_wr & (addr == ADDR_DATA);
   assign rx_flush  = status_wr & i_wb_data[ST_RX_FLUSH];
   assign tx_flush  = status_wr & i_wb_data[ST_TX_FLUSH];

   sync_fifo #(.AW(RX_AW), .DROP_OLDEST(1'b1)) u_rx_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_flush     (rx_flush),
      .i_push      (i_rx_stb),
      .i_push_data (i_rx_data),
      .i_pop       (rx_pop),
      .o_rd_data   (rx_rd_data),
      .o_count     (rx_count),
      .o_full      (rx_full),
      .o_empty     (rx_empty),
      .o_overflow  (rx_ovf)
   );

   sync_fifo #(.AW(TX_AW), .DROP_OLDEST(1'b0)) u_tx_fifo (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_flush     (tx_flush),
      .i_push      (tx_push),
      .i_push_data (i_wb_data[7:0]),
      .i_pop       (tx_pop),
      .o_rd_data   (o_tx_data),
      .o_count     (tx_count),
      .o_full      (tx_full),
      .o_empty     (tx_empty),
      .o_overflow  (tx_ovf)
   );

   // Sticky flags: software clear first, so a same-cycle new event wins
   always_comb begin
      rx_overrun_d  = rx_overrun_q;
      tx_overflow_d = tx_overflow_q;
      if (status_wr && i_wb_data[ST_RX_OVERRUN]) begin
         rx_overrun_d = 1'b0;
      end
      if (status_wr && i_wb_data[ST_TX_OVERFLOW]) begin
         tx_overflow_d = 1'b0;
      end
      if (rx_ovf) begin
         rx_overrun_d = 1'b1;
      end
      if (tx_ovf) begin
         tx_overflow_d = 1'b1;
      end
   end

   // Read mux for non-DATA registers, sampled at the accept edge
   always_comb begin
      wb_data_d = 32'h0;
      if (wb_rd) begin
         case (addr)
            ADDR_STATUS: wb_data_d = pack_status(rx_overrun_q, tx_overflow_q, tx_full,
                                                 12'(tx_count), 12'(rx_count));
            ADDR_IRQ_EN: wb_data_d = {{(32-IRQ_W){1'b0}}, irq_en_q};
            default:     wb_data_d = 32'h0;
         endcase
      end
   end

   // Interrupt sources, evaluated on current state
   always_comb begin
      pending                 = '0;
      pending[IRQ_RX_AVAIL]   = (rx_count != '0);
      pending[IRQ_TX_EMPTY]   = (tx_count == '0);
      pending[IRQ_RX_OVERRUN] = rx_overrun_q;
   end

   // Bus response, flags, interrupt enable and registered interrupt
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ack_q         <= 1'b0;
         data_sel_q    <= 1'b0;
         rd_valid_q    <= 1'b0;
         wb_data_q     <= 32'h0;
         rx_overrun_q  <= 1'b0;
         tx_overflow_q <= 1'b0;
         irq_en_q      <= '0;
         irq_q         <= 1'b0;
      end else begin
         ack_q         <= accept;
         rx_overrun_q  <= rx_overrun_d;
         tx_overflow_q <= tx_overflow_d;
         irq_q         <= |(irq_en_q & pending);
         if (accept) begin
            data_sel_q <= rx_pop;
            rd_valid_q <= rx_pop & ~rx_empty;
            wb_data_q  <= wb_data_d;
         end
         if (irq_en_wr) begin
            irq_en_q <= i_wb_data[IRQ_W-1:0];
         end
      end
   end

   // TX drain state register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tx_state_q <= TX_IDLE;
      end else begin
         tx_state_q <= tx_state_d;
      end
   end

   // TX drain next state: pop on leave-IDLE, strobe in SEND, one HOLD cycle
   always_comb begin
      tx_state_d = tx_state_q;
      tx_pop     = 1'b0;
      o_tx_stb   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            if (!tx_empty && !i_tx_busy && !tx_flush) begin
               tx_pop     = 1'b1;
               tx_state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            o_tx_stb   = 1'b1;
            tx_state_d = TX_HOLD;
         end
         TX_HOLD: begin
            // Transmitter may not raise busy until after the strobe
            tx_state_d = TX_IDLE;
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // The popped RX byte lives in the FIFO's read register, so DATA reads
   // select it alongside the ack instead of copying it again.
   assign o_wb_data  = data_sel_q ? {23'h0, rd_valid_q, (rd_valid_q ? rx_rd_data : 8'h00)}
                                  : wb_data_q;
   assign o_wb_ack   = ack_q & i_wb_cyc;
   assign o_wb_stall = 1'b0;
   assign o_wb_err   = 1'b0;
   assign o_irq      = irq_q;

endmodule

// File: tb/tb_wbuart_fifo.sv
// Self-checking bench for wbuart_fifo with 4-entry RX and TX FIFOs.
module tb_wbuart_fifo;

   localparam int K_RX = 0;
   localparam int K_WR = 1;
   localparam int K_RD = 2;

   typedef struct {
      int          kind;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic [7:0]  i_rx_data = 8'h00;
   logic        i_rx_stb = 1'b0;
   logic [7:0]  o_tx_data;
   logic        o_tx_stb;
   logic        i_tx_busy = 1'b0;
   logic        i_wb_cyc = 1'b0;
   logic        i_wb_stb = 1'b0;
   logic        i_wb_we = 1'b0;
   logic [3:0]  i_wb_sel = 4'hF;
   logic [29:0] i_wb_addr = 30'h0;
   logic [31:0] i_wb_data = 32'h0;
   logic        o_wb_stall;
   logic        o_wb_ack;
   logic        o_wb_err;
   logic [31:0] o_wb_data;
   logic        o_irq;

   int n_checks = 0;
   int n_pass   = 0;
   vec_t vecs[$];

   wbuart_fifo #(.RX_AW(2), .TX_AW(2)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_rx_data(i_rx_data), .i_rx_stb(i_rx_stb),
      .o_tx_data(o_tx_data), .o_tx_stb(o_tx_stb), .i_tx_busy(i_tx_busy),
      .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
      .i_wb_sel(i_wb_sel), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
      .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
      .o_wb_data(o_wb_data), .o_irq(o_irq)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("ok   %s: 0x%08h", name, act);
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input int kind, input logic [1:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input string name);
      vec_t v;
      v.kind = kind; v.addr = addr; v.wdata = wdata; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic wb_op(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                        output logic ack, output logic [31:0] rdata);
      @(negedge i_clk);
      i_wb_stb  = 1'b1;
      i_wb_we   = we;
      i_wb_addr = {28'h0, addr};
      i_wb_data = wdata;
      @(negedge i_clk);
      ack   = o_wb_ack;
      rdata = o_wb_data;
      i_wb_stb = 1'b0;
      i_wb_we  = 1'b0;
   endtask

   task automatic rx_inject(input logic [7:0] b);
      @(negedge i_clk);
      i_rx_stb  = 1'b1;
      i_rx_data = b;
      @(negedge i_clk);
      i_rx_stb  = 1'b0;
   endtask

   initial begin
      logic        ack;
      logic [31:0] rd;
      int          got;
      int          last;
      int          cyc;
      int          extra;

      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_reset  = 1'b0;
      i_wb_cyc = 1'b1;
      @(negedge i_clk);
      check("reset_irq",     32'(o_irq), 32'h0);
      check("reset_tx_stb",  32'(o_tx_stb), 32'h0);
      check("reset_tx_data", 32'(o_tx_data), 32'h0);
      check("reset_ack",     32'(o_wb_ack), 32'h0);
      check("reset_wb_data", o_wb_data, 32'h0);

      // Register-level vectors
      add(K_RD, 2'd0, 32'h0, 32'h0000_0000, "status_reset");
      add(K_RD, 2'd1, 32'h0, 32'h0000_0000, "data_empty");
      add(K_RX, 2'd0, 32'h41, 32'h0, "");
      add(K_RX, 2'd0, 32'h42, 32'h0, "");
      add(K_RD, 2'd1, 32'h0, 32'h0000_0141, "data_0x41");
      add(K_RD, 2'd1, 32'h0, 32'h0000_0142, "data_0x42");
      add(K_RD, 2'd0, 32'h0, 32'h0000_0000, "status_drained");
      for (int i = 1; i <= 5; i++) add(K_RX, 2'd0, 32'(i), 32'h0, "");
      add(K_RD, 2'd0, 32'h0, 32'h8000_0004, "status_overrun");
      for (int i = 2; i <= 5; i++) add(K_RD, 2'd1, 32'h0, 32'h100 + 32'(i), "data_after_overrun");
      add(K_RD, 2'd1, 32'h0, 32'h0000_0000, "data_empty_again");
      add(K_RD, 2'd0, 32'h0, 32'h8000_0000, "status_overrun_sticky");
      add(K_WR, 2'd0, 32'h8000_0000, 32'h0, "status_clear_ovr");
      add(K_RD, 2'd0, 32'h0, 32'h0000_0000, "status_cleared");
      add(K_WR, 2'd2, 32'hFFFF_FFFE, 32'h0, "irq_en_wr");
      add(K_RD, 2'd2, 32'h0, 32'h0000_0006, "irq_en_rd");
      add(K_WR, 2'd2, 32'h0, 32'h0, "irq_en_wr0");
      add(K_RD, 2'd2, 32'h0, 32'h0000_0000, "irq_en_rd0");
      add(K_WR, 2'd3, 32'hFFFF_FFFF, 32'h0, "rsvd_wr");
      add(K_RD, 2'd3, 32'h0, 32'h0000_0000, "rsvd_rd");

      foreach (vecs[i]) begin
         if (vecs[i].kind == K_RX) begin
            rx_inject(vecs[i].wdata[7:0]);
         end else begin
            wb_op(vecs[i].kind == K_WR, vecs[i].addr, vecs[i].wdata, ack, rd);
            check({vecs[i].name, "_ack"}, 32'(ack), 32'h1);
            if (vecs[i].kind == K_RD) check(vecs[i].name, rd, vecs[i].exp);
         end
      end

      // TX overflow with transmitter busy, then drain of four bytes
      i_tx_busy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wb_op(1'b1, 2'd1, 32'hA1 + 32'(i), ack, rd);
      end
      wb_op(1'b0, 2'd0, 32'h0, ack, rd);
      check("tx_status_full", rd, 32'h6004_0000);
      check("tx_no_stb_busy", 32'(o_tx_stb), 32'h0);
      @(negedge i_clk);
      i_tx_busy = 1'b0;
      got = 0; last = -10; cyc = 0;
      while (got < 4 && cyc < 60) begin
         @(negedge i_clk);
         cyc++;
         if (o_tx_stb) begin
            check("tx_byte", 32'(o_tx_data), 32'hA1 + 32'(got));
            if (got > 0) check("tx_gap_ge3", 32'(cyc - last >= 3), 32'h1);
            last = cyc;
            got++;
         end
      end
      check("tx_pulse_count", 32'(got), 32'h4);
      extra = 0;
      repeat (10) begin
         @(negedge i_clk);
         if (o_tx_stb) extra++;
      end
      check("tx_no_fifth", 32'(extra), 32'h0);
      wb_op(1'b0, 2'd0, 32'h0, ack, rd);
      check("tx_overflow_sticky", rd, 32'h4000_0000);
      wb_op(1'b1, 2'd0, 32'h4000_0000, ack, rd);
      wb_op(1'b0, 2'd0, 32'h0, ack, rd);
      check("tx_overflow_cleared", rd, 32'h0000_0000);

      // Minimum push-to-strobe latency
      @(negedge i_clk);
      i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = 30'd1; i_wb_data = 32'hC3;
      @(negedge i_clk);
      i_wb_stb = 1'b0; i_wb_we = 1'b0;
      check("lat_stb_c1", 32'(o_tx_stb), 32'h0);
      @(negedge i_clk);
      check("lat_stb_c2", 32'(o_tx_stb), 32'h1);
      check("lat_data", 32'(o_tx_data), 32'hC3);
      @(negedge i_clk);
      check("lat_stb_c3", 32'(o_tx_stb), 32'h0);

      // RX-available interrupt
      wb_op(1'b1, 2'd2, 32'h1, ack, rd);
      rx_inject(8'h5A);
      check("irq_lag1", 32'(o_irq), 32'h0);
      @(negedge i_clk);
      check("irq_set", 32'(o_irq), 32'h1);
      wb_op(1'b0, 2'd1, 32'h0, ack, rd);
      check("irq_data", rd, 32'h0000_015A);
      check("irq_still", 32'(o_irq), 32'h1);
      @(negedge i_clk);
      check("irq_drop", 32'(o_irq), 32'h0);
      wb_op(1'b1, 2'd2, 32'h0, ack, rd);

      // Full RX: push and pop in the same cycle
      for (int i = 0; i < 4; i++) rx_inject(8'h11 + 8'(i));
      @(negedge i_clk);
      i_rx_stb = 1'b1; i_rx_data = 8'h15;
      i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 30'd1;
      @(negedge i_clk);
      check("pp_ack", 32'(o_wb_ack), 32'h1);
      check("pp_data", o_wb_data, 32'h0000_0111);
      i_rx_stb = 1'b0; i_wb_stb = 1'b0;
      wb_op(1'b0, 2'd0, 32'h0, ack, rd);
      check("pp_status", rd, 32'h0000_0004);
      wb_op(1'b0, 2'd1, 32'h0, ack, rd);
      check("pp_next", rd, 32'h0000_0112);
      wb_op(1'b1, 2'd0, 32'h0000_0001, ack, rd);
      wb_op(1'b0, 2'd0, 32'h0, ack, rd);
      check("flush_status", rd, 32'h0000_0000);
      wb_op(1'b0, 2'd1, 32'h0, ack, rd);
      check("flush_data", rd, 32'h0000_0000);

      // Ack suppressed when cyc drops in the ack cycle
      @(negedge i_clk);
      i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 30'd0;
      @(negedge i_clk);
      i_wb_stb = 1'b0; i_wb_cyc = 1'b0;
      #1;
      check("cyc_low_ack", 32'(o_wb_ack), 32'h0);
      // No transfer accepted while cyc is low
      @(negedge i_clk);
      i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_addr = 30'd2; i_wb_data = 32'h7;
      @(negedge i_clk);
      check("cyc_low_no_ack", 32'(o_wb_ack), 32'h0);
      i_wb_stb = 1'b0; i_wb_we = 1'b0; i_wb_cyc = 1'b1;
      wb_op(1'b0, 2'd2, 32'h0, ack, rd);
      check("cyc_low_no_write", rd, 32'h0000_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/wbuart_fifo.md
# wbuart_fifo

Wishbone-attached UART buffer with parametrised-depth receive and transmit FIFOs, sticky error flags, software flush and a maskable interrupt. It sits between the CPU data bus and an external byte-serial RX/TX pair (strobe-in receiver, strobe/busy transmitter). It replaces single-direction buffering with buffered TX, so software can queue bursts without polling `i_tx_busy`.

## Interface
- `RX_AW`, 9: log2 RX FIFO depth; depth = 2^RX_AW entries (full depth usable); legal 2..11.
- `TX_AW`, 4: log2 TX FIFO depth; legal 2..11.
- `i_clk` in 1: single clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_rx_data` in 8: received byte; `i_rx_stb` in 1: one-cycle valid strobe.
- `o_tx_data` out 8: byte to transmit; `o_tx_stb` out 1: one-cycle start pulse; `i_tx_busy` in 1: transmitter busy.
- `i_wb_cyc`, `i_wb_stb`, `i_wb_we` in 1; `i_wb_sel` in 4 (ignored); `i_wb_addr` in 30 (bits [1:0] decoded); `i_wb_data` in 32.
- `o_wb_stall` out 1: constant 0; `o_wb_ack` out 1; `o_wb_err` out 1: constant 0; `o_wb_data` out 32.
- `o_irq` out 1: level interrupt.

## Operation
- Register map by `i_wb_addr[1:0]`:
  - 0 STATUS: read `{rx_overrun[31], tx_overflow[30], tx_full[29], 1'b0, tx_count[27:16] (zero-extended), 4'h0, rx_count[11:0] (zero-extended)}`. Write: bit31=1 clears rx_overrun, bit30=1 clears tx_overflow, bit0=1 flushes RX, bit1=1 flushes TX.
  - 1 DATA: read pops RX, returns `{23'h0, valid[8], byte[7:0]}`; empty → `32'h0`, no pop. Write pushes `i_wb_data[7:0]` to TX; TX full → byte dropped, tx_overflow set.
  - 2 IRQ_EN: R/W bits [2:0]; other bits read 0.
  - 3: reads 0, writes ignored, still acked.
- Pending sources: [0] rx_count≠0, [1] tx_count==0, [2] rx_overrun. `o_irq` = |(IRQ_EN & pending), registered.
- RX push on `i_rx_stb`. RX full and no pop in the same cycle → drop oldest (advance read pointer), store new byte, set rx_overrun. Push + pop in the same cycle while full → both happen, no overrun, count unchanged.
- rx_overrun and tx_overflow are sticky; cleared only by a STATUS write or reset (never by draining).
- Flush resets that FIFO's pointers. A same-cycle push into the flushed FIFO is discarded. Flush does not clear flags.
- Pointers are AW+1 bits wide; count = wr−rd (mod 2^(AW+1)); full when count == 2^AW. Wrap-around is natural.
- TX drain FSM:
  - TX_IDLE → TX_SEND when tx_count≠0 and !`i_tx_busy`. `o_tx_data` ← head byte, pop.
  - TX_SEND: `o_tx_stb`=1 for exactly one cycle → TX_HOLD.
  - TX_HOLD: one cycle, ignore busy (covers transmitter busy latency) → TX_IDLE.
- `i_wb_cyc` low: no new transfer accepted; an ack due that cycle is suppressed (the side effect already occurred).
- Reset values: `o_wb_ack`=0, `o_wb_data`=0, `o_tx_stb`=0, `o_tx_data`=0, `o_irq`=0, IRQ_EN=0, flags=0, all pointers=0, FSM=TX_IDLE.

## Timing
- Pipelined, never stalls. Request accepted on `i_wb_cyc & i_wb_stb`. `o_wb_ack` and `o_wb_data` are valid exactly one cycle later. Back-to-back requests give back-to-back acks.
- RX memory read is synchronous. The DATA-read byte is registered together with the ack.
- Status reflects state at the accept edge (before that cycle's own push/pop).
- Byte rate: at most one `o_tx_stb` per 3 cycles. Push-to-`o_tx_stb` minimum latency is 2 cycles (push edge, IDLE→SEND edge, stb high).
- `o_irq` lags its source by one cycle.

## Structure
- Package `wbuart_pkg`: register address constants, STATUS/IRQ bit positions, `tx_state_t` enum (TX_IDLE, TX_SEND, TX_HOLD).
- Sub-module `sync_fifo` (parameters AW, `DROP_OLDEST`): push, pop, flush, count, full/empty, synchronous read. Instantiated twice: RX with DROP_OLDEST=1, TX with DROP_OLDEST=0.

## Test plan
- Reset, then read STATUS → `32'h0`. Read DATA → `32'h0`. `o_irq`=0, `o_tx_stb`=0.
- Inject 0x41, 0x42, then read DATA twice → 0x141, 0x142. STATUS rx_count=0, rx_overrun=0.
- RX_AW=2: inject 5 bytes 0x01..0x05 → rx_count=4, rx_overrun=1. Reads return 0x102..0x105. Flag stays 1 until STATUS write 0x8000_0000.
- TX_AW=2, `i_tx_busy` held 1: write 5 bytes → tx_full=1, tx_overflow=1. Release busy → four `o_tx_stb` pulses with the first four bytes, ≥3 cycles apart.
- IRQ_EN=1, inject byte → `o_irq`=1 two cycles after the strobe. Read DATA → `o_irq` drops.
- Full RX: push and DATA read in the same cycle → count stays 4, no overrun. STATUS write 0x1 → rx_count=0.
